// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  localparam int unsigned INSTR_W = 32;

  // All-zero word decodes as a no-op; IF substitutes it for squashed fetches.
  localparam logic [INSTR_W-1:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction word array: synchronous write through the load port, combinational read.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned Depth = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [INSTR_W-1:0]       wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [INSTR_W-1:0]       rdata_o
);

  logic [INSTR_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch request/response interface: one outstanding fetch,
// fixed wait states, response held until accepted, flush aborts.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INSTR_W-1:0]       rsp_data,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [INSTR_W-1:0]       ld_data,
  output logic                     busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               rsp_valid_q;
  logic [INSTR_W-1:0] rsp_data_q;
  logic               rsp_err_q;

  logic [IdxW-1:0]    req_idx;
  logic [INSTR_W-1:0] rd_word;
  logic               fault;
  logic               accept;

  assign req_idx = req_addr[IdxW+1:2];
  // Any address bit above the word index means the fetch is out of range.
  assign fault   = (req_addr[1:0] != 2'b00) || ((req_addr >> (IdxW + 2)) != '0);

  imem_array #(
    .Depth(DEPTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (ld_en),
    .waddr_i(ld_addr),
    .wdata_i(ld_data),
    .raddr_i(req_idx),
    .rdata_o(rd_word)
  );

  assign req_ready = (state_q == StIdle) && rst_n;
  assign accept    = req_valid && req_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            // Word is captured here, so a same-edge load still returns the old word.
            rsp_data_q <= fault ? '0 : rd_word;
            rsp_err_q  <= fault;
            if (WAIT_CYCLES == 0) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (flush || rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with WAIT_CYCLES=2 and DEPTH=256.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        flush;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  imem_responder #(
    .ADDR_W     (32),
    .DEPTH      (256),
    .WAIT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = idx;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // Full fetch with rsp_ready high; optional same-edge load to the fetched word.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input logic collide, input logic [31:0] cdata);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = addr;
    if (collide) begin
      ld_en   = 1'b1;
      ld_addr = addr[9:2];
      ld_data = cdata;
    end
    check_eq({tag, " ready_before"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    ld_en     = 1'b0;
    check_eq({tag, " T+1 valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, " T+1 ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, " T+1 busy"}, 32'(busy), 32'd1);
    tick();
    check_eq({tag, " T+2 valid"}, 32'(rsp_valid), 32'd0);
    tick();
    check_eq({tag, " T+3 valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, " T+3 ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, " data"}, rsp_data, exp_data);
    check_eq({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    tick();
    check_eq({tag, " T+4 valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, " T+4 ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, " T+4 busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    tick();
    tick();
    check_eq("rst valid", 32'(rsp_valid), 32'd0);
    check_eq("rst data", rsp_data, 32'd0);
    check_eq("rst err", 32'(rsp_err), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post-rst ready", 32'(req_ready), 32'd1);

    load_word(8'd4, 32'h8C22_0004);
    load_word(8'd0, 32'h1234_5678);

    do_fetch("fetch 0x10", 32'h10, 32'h8C22_0004, 1'b0, 1'b0, 32'h0);
    do_fetch("misaligned 0x12", 32'h12, 32'h0, 1'b1, 1'b0, 32'h0);
    do_fetch("range 0x400", 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);
    do_fetch("fetch 0x0", 32'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);

    // Backpressure: response must hold until rsp_ready.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("bp valid", 32'(rsp_valid), 32'd1);
    held = rsp_data;
    check_eq("bp data", held, 32'h8C22_0004);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp hold valid", 32'(rsp_valid), 32'd1);
      check_eq("bp hold data", rsp_data, 32'h8C22_0004);
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp release valid", 32'(rsp_valid), 32'd0);
    check_eq("bp release ready", 32'(req_ready), 32'd1);

    // Flush one cycle after accept.
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush wait busy", 32'(busy), 32'd0);
    check_eq("flush wait ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("flush no rsp", 32'(rsp_valid), 32'd0);
    end
    do_fetch("post-flush 0x0", 32'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);

    // Flush in IDLE blocks the request.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check_eq("flush idle busy", 32'(busy), 32'd0);
    tick();
    tick();
    check_eq("flush idle no rsp", 32'(rsp_valid), 32'd0);

    // Flush drops a pending response.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("flush resp pre", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush resp valid", 32'(rsp_valid), 32'd0);
    check_eq("flush resp ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;

    // Same-edge load returns the old word; the next fetch sees the new one.
    do_fetch("collide 0x10", 32'h10, 32'h8C22_0004, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_fetch("refetch 0x10", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);

    // Reset while in WAIT.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    check_eq("pre-rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("mid-rst valid", 32'(rsp_valid), 32'd0);
    check_eq("mid-rst busy", 32'(busy), 32'd0);
    check_eq("mid-rst ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("mid-rst release ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid-rst no stale", 32'(rsp_valid), 32'd0);
    end
    do_fetch("post-rst mem kept", 32'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
